// File: rtl/ahb_slave_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ahb_slave_arbiter_pkg: shared types and constants for the AHB slave-port arbiters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ahb_slave_arbiter_pkg;

   localparam int AHB_MASTER_NUM = 4;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      OKAY  = 2'b00,
      ERROR = 2'b01,
      RETRY = 2'b10,
      SPLIT = 2'b11
   } hresp_type_e;

endpackage

`default_nettype wire

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// ahb_rr_picker: combinational round-robin selector, first unmasked requester after rr_ptr
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_rr_picker
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = AHB_MASTER_NUM,
   parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
   input  logic [MASTER_NUM-1:0] req,
   input  logic [MASTER_NUM-1:0] mask,
   input  logic [MIDX_W-1:0]     rr_ptr,
   output logic [MIDX_W-1:0]     winner,
   output logic                  found
);

   logic [MASTER_NUM-1:0] cand;
   int                    idx;

   assign cand = req & ~mask;

   // Scan from farthest to nearest so the nearest hit after rr_ptr is the last one written.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = MASTER_NUM; i >= 1; i--) begin
         idx = (int'(rr_ptr) + i) % MASTER_NUM;
         if (cand[idx]) begin
            winner = idx[MIDX_W-1:0];
            found  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_slave_arbiter: round-robin, burst-holding arbiter for one AHB slave port.
// Optional split support via macro AHB_ARB_SPLIT_EN. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_slave_arbiter
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int MASTER_NUM = AHB_MASTER_NUM,
   parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
   input  logic                  hclk,
   input  logic                  hreset_n,
   input  logic [MASTER_NUM-1:0] hreq,
   input  logic [MASTER_NUM-1:0] hlast,
   input  logic                  hready,
   input  logic [1:0]            hresp,
`ifdef AHB_ARB_SPLIT_EN
   input  logic [MASTER_NUM-1:0] hsplit_resume,
`endif
   output logic [MASTER_NUM-1:0] hgrant,
   output logic [MIDX_W-1:0]     hmaster_addr,
   output logic [MIDX_W-1:0]     hmaster_data,
   output logic                  hgrant_valid
);

   arb_state_e            state;
   logic [MIDX_W-1:0]     rr_ptr;
   logic [MASTER_NUM-1:0] mask;
   logic                  split_pend;
   logic [MIDX_W-1:0]     winner;
   logic                  found;
   logic                  release_ok;
   logic [MASTER_NUM-1:0] winner_onehot;

   ahb_rr_picker #(
      .MASTER_NUM (MASTER_NUM),
      .MIDX_W     (MIDX_W)
   ) u_picker (
      .req    (hreq),
      .mask   (mask),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .found  (found)
   );

`ifdef AHB_ARB_SPLIT_EN
   logic [MASTER_NUM-1:0] split_set;

   always_comb begin
      split_set = '0;
      if (hresp == SPLIT && !hready)
         split_set[hmaster_data] = 1'b1;
   end

   // A SPLIT response is two cycles: hready low marks the master, the next hready-high edge releases it.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         mask       <= '0;
         split_pend <= 1'b0;
      end else begin
         mask <= (mask & ~hsplit_resume) | split_set;
         if (hresp == SPLIT && !hready)
            split_pend <= 1'b1;
         else if (hready)
            split_pend <= 1'b0;
      end
   end
`else
   logic unused_hresp;

   assign unused_hresp = ^hresp;
   assign mask         = '0;
   assign split_pend   = 1'b0;
`endif

   assign release_ok    = hready && (hlast[hmaster_addr] || !hreq[hmaster_addr] || split_pend);
   assign winner_onehot = {{(MASTER_NUM-1){1'b0}}, 1'b1} << winner;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state        <= ARB_IDLE;
         hgrant       <= '0;
         hgrant_valid <= 1'b0;
         hmaster_addr <= '0;
         hmaster_data <= '0;
         rr_ptr       <= MIDX_W'(MASTER_NUM - 1);
      end else begin
         if (hready)
            hmaster_data <= hmaster_addr;

         case (state)
            ARB_IDLE: begin
               if (found) begin
                  hgrant       <= winner_onehot;
                  hgrant_valid <= 1'b1;
                  hmaster_addr <= winner;
                  rr_ptr       <= winner;
                  state        <= ARB_OWN;
               end else begin
                  hgrant       <= '0;
                  hgrant_valid <= 1'b0;
               end
            end
            ARB_OWN: begin
               // rr_ptr equals the owner here, so a lone re-request from the owner wins last in rotation.
               if (release_ok) begin
                  if (found) begin
                     hgrant       <= winner_onehot;
                     hgrant_valid <= 1'b1;
                     hmaster_addr <= winner;
                     rr_ptr       <= winner;
                  end else begin
                     hgrant       <= '0;
                     hgrant_valid <= 1'b0;
                     state        <= ARB_IDLE;
                  end
               end
            end
            default: begin
               hgrant       <= '0;
               hgrant_valid <= 1'b0;
               state        <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_arbiter: directed self-checking bench for ahb_slave_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ahb_slave_arbiter;

   logic       hclk;
   logic       hreset_n;
   logic [3:0] hreq;
   logic [3:0] hlast;
   logic       hready;
   logic [1:0] hresp;
   logic [3:0] hsplit_resume;
   logic [3:0] hgrant;
   logic [1:0] hmaster_addr;
   logic [1:0] hmaster_data;
   logic       hgrant_valid;

   int total = 0;
   int bad   = 0;

   ahb_slave_arbiter #(
      .MASTER_NUM (4),
      .MIDX_W     (2)
   ) dut (
      .hclk          (hclk),
      .hreset_n      (hreset_n),
      .hreq          (hreq),
      .hlast         (hlast),
      .hready        (hready),
      .hresp         (hresp),
`ifdef AHB_ARB_SPLIT_EN
      .hsplit_resume (hsplit_resume),
`endif
      .hgrant        (hgrant),
      .hmaster_addr  (hmaster_addr),
      .hmaster_data  (hmaster_data),
      .hgrant_valid  (hgrant_valid)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic apply_reset();
      hreset_n      = 1'b0;
      hreq          = '0;
      hlast         = '0;
      hready        = 1'b1;
      hresp         = 2'b00;
      hsplit_resume = '0;
      step();
      step();
      hreset_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL reset_hgrant got=%b exp=0000", hgrant); end
      total++; if (hgrant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", hgrant_valid); end
      total++; if (hmaster_addr !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", hmaster_addr); end
      total++; if (hmaster_data !== 2'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", hmaster_data); end
   endtask

   task automatic test_single();
      hreq = 4'b0100; hlast = 4'b0100; hready = 1'b1;
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL single_nocomb got=%b exp=0000", hgrant); end
      step();
      total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b exp=0100", hgrant); end
      total++; if (hmaster_addr !== 2'd2) begin bad++; $display("FAIL single_addr got=%0d exp=2", hmaster_addr); end
      total++; if (hgrant_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", hgrant_valid); end
      hreq = 4'b0000;
      step();
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL single_release got=%b exp=0000", hgrant); end
      total++; if (hmaster_data !== 2'd2) begin bad++; $display("FAIL single_data got=%0d exp=2", hmaster_data); end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g [5];
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      apply_reset();
      hreq = 4'b1111; hlast = 4'b1111; hready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (hgrant !== exp_g[i]) begin bad++; $display("FAIL rotate_%0d got=%b exp=%b", i, hgrant, exp_g[i]); end
      end
      hreq = 4'b0000;
      step();
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL rotate_idle got=%b exp=0000", hgrant); end
   endtask

   task automatic test_burst();
      hreq = 4'b0010; hlast = 4'b0000; hready = 1'b1;
      step();
      total++; if (hgrant !== 4'b0010) begin bad++; $display("FAIL burst_grant got=%b exp=0010", hgrant); end
      hreq = 4'b1010;
      step();
      hready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (hgrant !== 4'b0010) begin bad++; $display("FAIL burst_wait_%0d got=%b exp=0010", i, hgrant); end
      end
      hready = 1'b1;
      step();
      step();
      total++; if (hgrant !== 4'b0010) begin bad++; $display("FAIL burst_beat3 got=%b exp=0010", hgrant); end
      hlast = 4'b0010;
      step();
      total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL burst_handoff got=%b exp=1000", hgrant); end
      total++; if (hmaster_addr !== 2'd3) begin bad++; $display("FAIL burst_addr got=%0d exp=3", hmaster_addr); end
      total++; if (hmaster_data !== 2'd1) begin bad++; $display("FAIL burst_data_lag got=%0d exp=1", hmaster_data); end
      hreq = 4'b1000; hlast = 4'b0000; hready = 1'b0;
      step();
      total++; if (hmaster_data !== 2'd1) begin bad++; $display("FAIL burst_data_frozen got=%0d exp=1", hmaster_data); end
      total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL burst_hold3 got=%b exp=1000", hgrant); end
      hlast = 4'b1000; hready = 1'b1;
      step();
      total++; if (hmaster_data !== 2'd3) begin bad++; $display("FAIL burst_data_adv got=%0d exp=3", hmaster_data); end
      total++; if (hgrant !== 4'b1000) begin bad++; $display("FAIL burst_regrant got=%b exp=1000", hgrant); end
   endtask

   task automatic test_wrap();
      hreq = 4'b0001; hlast = 4'b1001; hready = 1'b1; hresp = 2'b01;
      step();
      total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL wrap_grant got=%b exp=0001", hgrant); end
      total++; if (hmaster_addr !== 2'd0) begin bad++; $display("FAIL wrap_addr got=%0d exp=0", hmaster_addr); end
      hreq = 4'b0000; hlast = 4'b1111; hresp = 2'b00;
      step();
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL wrap_release got=%b exp=0000", hgrant); end
      total++; if (hgrant_valid !== 1'b0) begin bad++; $display("FAIL wrap_valid got=%b exp=0", hgrant_valid); end
      step();
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL wrap_idle got=%b exp=0000", hgrant); end
   endtask

   task automatic test_reset_mid();
      hreq = 4'b0100; hlast = 4'b0000; hready = 1'b1;
      step();
      total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL rstmid_grant got=%b exp=0100", hgrant); end
      #2;
      hreset_n = 1'b0;
      #1;
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL rstmid_async_grant got=%b exp=0000", hgrant); end
      total++; if (hmaster_addr !== 2'd0) begin bad++; $display("FAIL rstmid_async_addr got=%0d exp=0", hmaster_addr); end
      total++; if (hgrant_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async_valid got=%b exp=0", hgrant_valid); end
      hreq = 4'b1111;
      step();
      hreset_n = 1'b1;
      step();
      total++; if (hgrant !== 4'b0001) begin bad++; $display("FAIL rstmid_first got=%b exp=0001", hgrant); end
      hreq = 4'b0000; hlast = 4'b1111;
      step();
   endtask

`ifdef AHB_ARB_SPLIT_EN
   task automatic test_split();
      apply_reset();
      hreq = 4'b0100; hlast = 4'b0000; hready = 1'b1;
      step();
      total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL split_grant got=%b exp=0100", hgrant); end
      step();
      hresp = 2'b11; hready = 1'b0;
      step();
      total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL split_hold got=%b exp=0100", hgrant); end
      hready = 1'b1;
      step();
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL split_release got=%b exp=0000", hgrant); end
      hresp = 2'b00;
      step();
      total++; if (hgrant !== 4'b0000) begin bad++; $display("FAIL split_masked got=%b exp=0000", hgrant); end
      hsplit_resume = 4'b0100;
      step();
      hsplit_resume = 4'b0000;
      step();
      total++; if (hgrant !== 4'b0100) begin bad++; $display("FAIL split_resume got=%b exp=0100", hgrant); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_burst();
      test_wrap();
      test_reset_mid();
`ifdef AHB_ARB_SPLIT_EN
      test_split();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Per-slave-port arbiter in the generated AHB interconnect, directly downstream of every master's address decoder.
- Collects the per-master hreq bits targeting this slave and issues a one-hot hgrant back to the decoders.
- Drives address-phase and data-phase owner indices, which steer the slave-side address/data muxes.
- Round-robin fairness; ownership is held for a whole burst and released only at a transfer boundary with hready high.

Parameters:
- MASTER_NUM, 4, number of masters that can request this slave (≥2).
- MIDX_W, $clog2(MASTER_NUM), width of the owner index outputs.

Ports:
- hclk  in  1  AHB clock.
- hreset_n  in  1  asynchronous, active-low reset.
- hreq  in  MASTER_NUM  per-master request from the decoders; bit i is master i.
- hlast  in  MASTER_NUM  per-master "current beat is last of burst" (single transfer = last).
- hready  in  1  slave HREADYOUT; transfer-boundary qualifier.
- hresp  in  2  slave response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11).
- hsplit_resume  in  MASTER_NUM  slave split-resume bits (AHB_ARB_SPLIT_EN only).
- hgrant  out  MASTER_NUM  one-hot grant, registered.
- hmaster_addr  out  MIDX_W  index of the address-phase owner.
- hmaster_data  out  MIDX_W  index of the data-phase owner.
- hgrant_valid  out  1  any grant active.

Behaviour:
- Reset values:
  - hgrant = 0, hgrant_valid = 0, hmaster_addr = 0, hmaster_data = 0.
  - Round-robin pointer rr_ptr = MASTER_NUM-1, so master 0 wins first.
  - Split mask = 0.
- FSM states: ARB_IDLE, ARB_OWN.
- ARB_IDLE:
  - If any unmasked hreq: pick winner w, register hgrant = onehot(w), hmaster_addr = w, rr_ptr = w; go to ARB_OWN.
  - Else stay; outputs unchanged except hgrant = 0.
- Latency: hreq sampled at edge N gives hgrant visible from edge N+1. No combinational path from hreq to hgrant.
- ARB_OWN, release condition: hready && (hlast[owner] || !hreq[owner]).
- On release:
  - Other unmasked request present: re-arbitrate in the same cycle, new one-hot grant from the next edge (back-to-back, no idle cycle); stay in ARB_OWN.
  - None: hgrant = 0, go to ARB_IDLE.
  - Only the owner still requesting (new burst): it is regranted.
- Without release, hgrant holds even while hready is low (wait states).
- Winner selection: first unmasked requester scanning rr_ptr+1, rr_ptr+2, … modulo MASTER_NUM. Wrap from MASTER_NUM-1 to 0 is required.
- Data-phase pipeline: on every hready-high edge, hmaster_data <= hmaster_addr. hmaster_data is frozen while hready is low.
- hgrant_valid = |hgrant, registered alongside hgrant.
- Simultaneous events:
  - Release and a new request from the owner in the same cycle: treated as a new request, subject to round-robin.
  - Requests from all masters: strict rotation, one burst each.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous); no pending state is retained.
- ERROR and RETRY do not affect arbitration. The owner ends the burst by dropping hreq.

Optional Feature:
- Macro: AHB_ARB_SPLIT_EN.
- With the macro defined:
  - A data-phase hresp == SPLIT with hready low sets mask[hmaster_data].
  - The owner is released on the following hready-high edge, regardless of hlast.
  - Masked masters are excluded from selection.
  - hsplit_resume[i] clears mask[i] on the next edge.
  - When set and clear of the same bit coincide, set wins.
- Without the macro: the hsplit_resume port is absent, hresp is unused, and the mask is constant 0.

Decomposition:
- AHB_package gains:
  - arb_state_e {ARB_IDLE, ARB_OWN}
  - hresp_type enum (OKAY, ERROR, RETRY, SPLIT)
  - AHB_MASTER_NUM default constant
- Sub-module ahb_rr_picker: combinational. Inputs req, mask, rr_ptr; outputs winner index and found flag. Reused by later arbiter variants.

Test Plan:
- Reset → hgrant=0, hmaster_addr=0, hmaster_data=0. Single hreq=4'b0100 → hgrant=4'b0100 one cycle later, hmaster_addr=2.
- hreq=4'b1111, each master sends single transfers with hlast=1 and hready=1 → grants rotate 0,1,2,3,0 on consecutive cycles.
- Master 1 runs a 4-beat burst (hlast on beat 4) while master 3 requests, hready low for 2 cycles on beat 2 → hgrant stays 4'b0010 until beat 4 completes, then 4'b1000. hmaster_data lags hmaster_addr by one hready-high edge.
- Owner 3 finishes while only master 0 requests → winner 0 (wrap-around). With no requests → hgrant=0, FSM returns to ARB_IDLE.
- hreset_n asserted mid-burst → outputs 0 in the same cycle. After release, master 0 wins first.
- AHB_ARB_SPLIT_EN: slave returns SPLIT to master 2 → master 2 masked and not granted despite hreq. hsplit_resume[2]=1 → master 2 granted on its next round-robin turn.
